// File: rtl/rtc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_bus_ctrl
//
// Sequences one read or write access to an RTC chip that uses a multiplexed
// address/data bus. Each transaction walks through:
//   IDLE -> ADDR_SETUP -> ADDR_STROBE -> ADDR_GAP -> DATA_STROBE -> RECOVER
// The address is presented first with an address strobe (cs_n + wr_n); the
// data phase then either drives write data (wr_n) or samples the bus (rd_n).
//
// Every output comes straight from a flop. The output flops are loaded with
// the values that belong to the state being entered on that edge, so the
// pins change on the same edge the FSM changes state, and no input ever
// reaches an output pin combinationally.
//
// Ports
//   clk          in   clock, rising-edge active
//   reset        in   asynchronous, active-high reset
//   start        in   transaction request, only looked at in IDLE
//   wr_mode      in   1 = write transaction, 0 = read transaction
//   addr         in   [DW] RTC register address
//   wdata        in   [DW] write data
//   bus_in       in   [DW] value seen on the RTC bus pads
//   bus_out      out  [DW] value driven onto the RTC bus pads
//   bus_oe       out  pad output enable (1 = bus_out is driven)
//   a_d          out  address/data select (0 = address, 1 = data)
//   cs_n         out  active-low chip select
//   wr_n         out  active-low write strobe
//   rd_n         out  active-low read strobe
//   busy         out  high while a transaction is in progress
//   done         out  one-cycle pulse in the first IDLE cycle after RECOVER
//   rdata        out  [DW] last captured read data
//   rdata_valid  out  one-cycle pulse with done, read transactions only
// ---------------------------------------------------------------------------
module rtc_bus_ctrl #(
  parameter int DW       = 8,
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_GAP    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_mode,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          a_d,
  output logic          cs_n,
  output logic          wr_n,
  output logic          rd_n,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid
);

  // Counter must be able to hold the longest phase length minus one.
  localparam int MAX_T = (T_SETUP > T_STROBE)
                         ? ((T_SETUP  > T_GAP) ? T_SETUP  : T_GAP)
                         : ((T_STROBE > T_GAP) ? T_STROBE : T_GAP);
  localparam int CW = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(T_SETUP  - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(T_GAP    - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    ADDR_GAP,
    DATA_STROBE,
    RECOVER
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          phase_last;

  // Operands held stable for the whole transaction.
  logic          op_wr;
  logic [DW-1:0] op_addr;
  logic [DW-1:0] op_wdata;

  // Operand view used to compute output flop inputs. On the accepting edge
  // the latches are not yet loaded, so the live inputs are used instead.
  logic          src_wr;
  logic [DW-1:0] src_addr;
  logic [DW-1:0] src_wdata;

  // Next values for the output flops.
  logic [DW-1:0] nxt_bus_out;
  logic          nxt_bus_oe;
  logic          nxt_a_d;
  logic          nxt_cs_n;
  logic          nxt_wr_n;
  logic          nxt_rd_n;
  logic          nxt_busy;
  logic          nxt_done;
  logic          nxt_rdata_valid;
  logic          capture;

  // High during the final cycle of the current timed phase.
  always_comb begin
    phase_last = 1'b0;
    case (state)
      ADDR_SETUP:               phase_last = (cnt == SETUP_LAST);
      ADDR_STROBE, DATA_STROBE: phase_last = (cnt == STROBE_LAST);
      ADDR_GAP, RECOVER:        phase_last = (cnt == GAP_LAST);
      default:                  phase_last = 1'b0;
    endcase
  end

  // State register and phase counter. The counter restarts at zero on every
  // state change and rests at zero in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state || state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Operand latches: loaded only when a request is accepted in IDLE, so a
  // start seen during a transaction cannot disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_wr    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
    end else if (state == IDLE && start) begin
      op_wr    <= wr_mode;
      op_addr  <= addr;
      op_wdata <= wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (start)      next_state = ADDR_SETUP;
      ADDR_SETUP:  if (phase_last) next_state = ADDR_STROBE;
      ADDR_STROBE: if (phase_last) next_state = ADDR_GAP;
      ADDR_GAP:    if (phase_last) next_state = DATA_STROBE;
      DATA_STROBE: if (phase_last) next_state = RECOVER;
      RECOVER:     if (phase_last) next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // Output decode for the state being entered. done/rdata_valid are derived
  // from leaving RECOVER rather than from entering IDLE, so the reset path
  // into IDLE can never produce a pulse.
  always_comb begin
    src_wr    = (state == IDLE) ? wr_mode : op_wr;
    src_addr  = (state == IDLE) ? addr    : op_addr;
    src_wdata = (state == IDLE) ? wdata   : op_wdata;

    nxt_bus_out     = '0;
    nxt_bus_oe      = 1'b0;
    nxt_a_d         = 1'b1;
    nxt_cs_n        = 1'b1;
    nxt_wr_n        = 1'b1;
    nxt_rd_n        = 1'b1;
    nxt_busy        = 1'b1;
    nxt_done        = (state == RECOVER) && phase_last;
    nxt_rdata_valid = (state == RECOVER) && phase_last && !op_wr;
    capture         = (state == DATA_STROBE) && phase_last && !op_wr;

    case (next_state)
      IDLE: begin
        nxt_busy = 1'b0;
      end
      ADDR_SETUP: begin
        nxt_a_d     = 1'b0;
        nxt_bus_out = src_addr;
        nxt_bus_oe  = 1'b1;
      end
      ADDR_STROBE: begin
        nxt_a_d     = 1'b0;
        nxt_bus_out = src_addr;
        nxt_bus_oe  = 1'b1;
        nxt_cs_n    = 1'b0;
        nxt_wr_n    = 1'b0;
      end
      ADDR_GAP: begin
        if (src_wr) begin
          nxt_bus_out = src_wdata;
          nxt_bus_oe  = 1'b1;
        end
      end
      DATA_STROBE: begin
        nxt_cs_n = 1'b0;
        if (src_wr) begin
          nxt_wr_n    = 1'b0;
          nxt_bus_out = src_wdata;
          nxt_bus_oe  = 1'b1;
        end else begin
          nxt_rd_n = 1'b0;
        end
      end
      RECOVER: begin
        nxt_bus_oe = 1'b0;
      end
      default: begin
        nxt_busy = 1'b0;
      end
    endcase
  end

  // Output flops. The asynchronous reset drives the pins straight to their
  // idle values, so an active strobe is released without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_out     <= '0;
      bus_oe      <= 1'b0;
      a_d         <= 1'b1;
      cs_n        <= 1'b1;
      wr_n        <= 1'b1;
      rd_n        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      bus_out     <= nxt_bus_out;
      bus_oe      <= nxt_bus_oe;
      a_d         <= nxt_a_d;
      cs_n        <= nxt_cs_n;
      wr_n        <= nxt_wr_n;
      rd_n        <= nxt_rd_n;
      busy        <= nxt_busy;
      done        <= nxt_done;
      rdata_valid <= nxt_rdata_valid;
    end
  end

  // Read data is sampled on the edge that closes the last read strobe cycle
  // and then held until the next read completes its strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_ctrl
//
// Self-checking bench for rtc_bus_ctrl. A default-parameter instance gets
// cycle-by-cycle pin checks against a phase model, with completed
// transactions scored from a queue of expected results. A second instance
// with all phase lengths at 1 checks the shortest legal timing. Strobe
// exclusivity and the read-strobe output-enable rule are checked on both
// instances every cycle.
// ---------------------------------------------------------------------------
module tb_rtc_bus_ctrl;

  localparam int S = 2;
  localparam int T = 4;
  localparam int G = 4;
  localparam int BUSY_LEN = S + 2 * T + 2 * G;
  localparam int CAP_CYCLE = S + 2 * T + G;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       start = 1'b0;
  logic       wr_mode = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] bus_in = 8'hFF;
  logic [7:0] bus_out;
  logic       bus_oe, a_d, cs_n, wr_n, rd_n, busy, done, rdata_valid;
  logic [7:0] rdata;

  logic       s_start = 1'b0;
  logic       s_wr_mode = 1'b0;
  logic [7:0] s_addr = 8'h00;
  logic [7:0] s_wdata = 8'h00;
  logic [7:0] s_bus_in = 8'h00;
  logic [7:0] s_bus_out;
  logic       s_bus_oe, s_a_d, s_cs_n, s_wr_n, s_rd_n, s_busy, s_done, s_rdata_valid;
  logic [7:0] s_rdata;

  typedef struct {
    bit         wr;
    logic [7:0] rdata;
    logic       rvalid;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_dones = 0;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.DW(8), .T_SETUP(S), .T_STROBE(T), .T_GAP(G)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_mode(wr_mode),
    .addr(addr), .wdata(wdata), .bus_in(bus_in), .bus_out(bus_out),
    .bus_oe(bus_oe), .a_d(a_d), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .busy(busy), .done(done), .rdata(rdata), .rdata_valid(rdata_valid)
  );

  rtc_bus_ctrl #(.DW(8), .T_SETUP(1), .T_STROBE(1), .T_GAP(1)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .wr_mode(s_wr_mode),
    .addr(s_addr), .wdata(s_wdata), .bus_in(s_bus_in), .bus_out(s_bus_out),
    .bus_oe(s_bus_oe), .a_d(s_a_d), .cs_n(s_cs_n), .wr_n(s_wr_n), .rd_n(s_rd_n),
    .busy(s_busy), .done(s_done), .rdata(s_rdata), .rdata_valid(s_rdata_valid)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected pins {busy,a_d,cs_n,wr_n,rd_n,bus_oe,done} in cycle k (1-based)
  // of a transaction at default timing.
  function automatic logic [6:0] traceExp(input int k, input bit wr);
    if (k <= S)                  return 7'b1_0_1_1_1_1_0;
    else if (k <= S + T)         return 7'b1_0_0_0_1_1_0;
    else if (k <= S + T + G)     return {5'b1_1_1_1_1, wr, 1'b0};
    else if (k <= S + 2 * T + G) return {3'b1_1_0, ~wr, wr, wr, 1'b0};
    else                         return 7'b1_1_1_1_1_0_0;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected transaction.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("sb_rdata_valid", 32'(rdata_valid), 32'(e.rvalid));
          if (!e.wr) checkOutput("sb_rdata", 32'(rdata), 32'(e.rdata));
        end
      end else begin
        checkOutput("rdata_valid_no_done", 32'(rdata_valid), 0);
      end
    end
  end

  // Pin-level safety rules on both instances, every cycle.
  always @(negedge clk) begin
    checkOutput("strobe_excl", 32'((!wr_n && !rd_n) || ((!wr_n || !rd_n) && cs_n)), 0);
    checkOutput("oe_read_strobe", 32'(bus_oe && !rd_n), 0);
    checkOutput("s_strobe_excl", 32'((!s_wr_n && !s_rd_n) || ((!s_wr_n || !s_rd_n) && s_cs_n)), 0);
    checkOutput("s_oe_read_strobe", 32'(s_bus_oe && !s_rd_n), 0);
  end

  // Runs one transaction on the default instance, starting just after a
  // falling edge with the DUT idle; returns at the falling edge of cycle
  // BUSY_LEN+1 (or right after an abort when abort_at is non-zero).
  task automatic applyStimulus(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] rd_val, input bit vary_bus,
                               input bit poke_start, input int abort_at);
    logic [6:0] ev;
    exp_t e;
    wr_mode = wr;
    addr    = a;
    wdata   = d;
    start   = 1'b1;
    if (abort_at == 0) begin
      e.wr     = wr;
      e.rdata  = vary_bus ? 8'(8'h40 + CAP_CYCLE) : rd_val;
      e.rvalid = !wr;
      sb_q.push_back(e);
      exp_dones++;
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= BUSY_LEN; k++) begin
      ev = traceExp(k, wr);
      checkOutput($sformatf("trace_c%0d", k),
                  32'({busy, a_d, cs_n, wr_n, rd_n, bus_oe, done}), 32'(ev));
      if (ev[1]) checkOutput($sformatf("bus_out_c%0d", k), 32'(bus_out),
                             32'((k <= S + T) ? a : d));
      if (abort_at == k) begin
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_pins", 32'({busy, a_d, cs_n, wr_n, rd_n, bus_oe, done}),
                    32'(7'b0_1_1_1_1_0_0));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (vary_bus) bus_in = 8'(8'h40 + k);
      else bus_in = (k > S + T + G && k <= CAP_CYCLE) ? rd_val : 8'hFF;
      start = poke_start && (k == 5 || k == 12);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("done_end", 32'({done, busy}), 32'(2'b10));
    if (!wr) checkOutput("rdata_end", 32'(rdata),
                         32'(vary_bus ? 8'(8'h40 + CAP_CYCLE) : rd_val));
  endtask

  initial begin
    int cnt;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_pins",
                32'({busy, a_d, cs_n, wr_n, rd_n, bus_oe, done, rdata_valid}),
                32'(8'b0_1_1_1_1_0_0_0));
    checkOutput("reset_rdata", 32'(rdata), 0);
    reset = 1'b0;
    @(negedge clk);

    // Shortest legal timing: write then read on the small instance.
    s_wr_mode = 1'b1; s_addr = 8'h12; s_wdata = 8'h34; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cnt = 0;
    while (s_busy && cnt < 20) begin cnt++; @(negedge clk); end
    checkOutput("small_busy_len", cnt, 5);
    checkOutput("small_done", 32'({s_done, s_rdata_valid}), 32'(2'b10));
    s_wr_mode = 1'b0; s_bus_in = 8'hA7; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cnt = 0;
    while (s_busy && cnt < 20) begin cnt++; @(negedge clk); end
    checkOutput("small_rd_busy_len", cnt, 5);
    checkOutput("small_rd_done", 32'({s_done, s_rdata_valid}), 32'(2'b11));
    checkOutput("small_rdata", 32'(s_rdata), 32'(8'hA7));

    // Write 0x5A to 0x21, then reads.
    applyStimulus(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 8'h23, 8'h00, 8'hC3, 1'b0, 1'b0, 0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h7E, 8'h00, 8'h00, 1'b1, 1'b0, 0);
    @(negedge clk);

    // start pulses during a transaction are ignored.
    applyStimulus(1'b1, 8'h30, 8'h99, 8'h00, 1'b0, 1'b1, 0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      checkOutput("idle_after_poke", 32'({busy, done}), 0);
    end

    // start held high: back-to-back reads, done every BUSY_LEN+1 cycles.
    bus_in = 8'h5D; wr_mode = 1'b0; addr = 8'h44; start = 1'b1;
    for (int n = 0; n < 2; n++) begin
      exp_t e;
      e.wr = 1'b0; e.rdata = 8'h5D; e.rvalid = 1'b1;
      sb_q.push_back(e);
      exp_dones++;
    end
    @(negedge clk);
    for (int k = 1; k <= 2 * (BUSY_LEN + 1); k++) begin
      bit edge_c;
      edge_c = (k == BUSY_LEN + 1) || (k == 2 * (BUSY_LEN + 1));
      checkOutput($sformatf("held_c%0d", k), 32'({done, busy}), 32'({edge_c, ~edge_c}));
      if (k == 2 * (BUSY_LEN + 1)) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("held_stops", 32'(busy), 0);

    // Reset during write DATA_STROBE: immediate release, no done.
    applyStimulus(1'b1, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0, S + T + G + 2);
    checkOutput("rdata_cleared", 32'(rdata), 0);
    for (int k = 0; k < 25; k++) begin
      checkOutput("no_done_after_abort", 32'({busy, done}), 0);
      @(negedge clk);
    end

    // First transaction after reset runs full length.
    applyStimulus(1'b0, 8'h11, 8'h00, 8'h6B, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);

    checkOutput("done_total", done_cnt, exp_dones);
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
